// File: rtl/pulse_start_det.sv
// Pulse start/end detector on DDC I/Q samples: two-stage |I|+|Q| magnitude pipeline
// feeding a hysteresis FSM that reports pulse start, activity and finished pulse length.
module pulse_start_det #(
    parameter logic [16:0] THR_HI  = 17'd2000,
    parameter logic [16:0] THR_LO  = 17'd1000,
    parameter int unsigned ON_CNT  = 8,
    parameter int unsigned OFF_CNT = 32,
    parameter int unsigned HOLDOFF = 1024
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               DDC_DEN,
    input  logic signed [15:0] DDC_DATI,
    input  logic signed [15:0] DDC_DATQ,
    output logic               MAG_DOE,
    output logic        [16:0] MAG_DAT,
    output logic               PULSSRT,
    output logic               PULS_ACT,
    output logic               LEN_VLD,
    output logic        [15:0] PULS_LEN
);

    localparam logic [7:0]  ON_C   = 8'(ON_CNT);
    localparam logic [7:0]  OFF_C  = 8'(OFF_CNT);
    localparam logic [15:0] HOLD_C = 16'(HOLDOFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACTIVE,
        S_TAIL,
        S_HOLD
    } state_t;

    // 16-bit unsigned result keeps |-32768| = 32768 exact.
    function automatic logic [15:0] abs16(input logic signed [15:0] x);
        logic [15:0] r;
        r = x[15] ? (~x + 16'd1) : x;
        return r;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [8:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {8'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0] abs_i_q, abs_q_q;
    logic        v1_q;
    logic [16:0] mag_q;
    logic        mag_doe_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let stage 2 see stage 1's new data early.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            abs_i_q   <= '0;
            abs_q_q   <= '0;
            v1_q      <= 1'b0;
            mag_q     <= '0;
            mag_doe_q <= 1'b0;
        end else begin
            v1_q      <= DDC_DEN;
            mag_doe_q <= v1_q;
            if (DDC_DEN) begin
                abs_i_q <= abs16(DDC_DATI);
                abs_q_q <= abs16(DDC_DATQ);
            end
            if (v1_q) begin
                mag_q <= {1'b0, abs_i_q} + {1'b0, abs_q_q};
            end
        end
    end

    state_t      state_q, state_d;
    logic [7:0]  run_q, run_d;
    logic [7:0]  tail_q, tail_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] len_q, len_d;
    logic        srt_q, srt_d;
    logic        act_q, act_d;
    logic        vld_q, vld_d;
    logic [15:0] plen_q, plen_d;

    logic mag_hi, mag_lo_ok;
    assign mag_hi    = (mag_q >= THR_HI);
    assign mag_lo_ok = (mag_q >= THR_LO);

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        tail_d  = tail_q;
        hold_d  = hold_q;
        len_d   = len_q;
        srt_d   = 1'b0;
        act_d   = act_q;
        vld_d   = 1'b0;
        plen_d  = plen_q;

        if (mag_doe_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (mag_hi) begin
                        len_d = 16'd1;
                        if (ON_C == 8'd1) begin
                            state_d = S_ACTIVE;
                            run_d   = '0;
                            srt_d   = 1'b1;
                            act_d   = 1'b1;
                        end else begin
                            state_d = S_ARM;
                            run_d   = 8'd1;
                        end
                    end
                end
                S_ARM: begin
                    if (mag_hi) begin
                        len_d = sat_add(len_q, 9'd1);
                        run_d = run_q + 8'd1;
                        if (run_q + 8'd1 == ON_C) begin
                            state_d = S_ACTIVE;
                            run_d   = '0;
                            srt_d   = 1'b1;
                            act_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                        run_d   = '0;
                        len_d   = '0;
                    end
                end
                S_ACTIVE: begin
                    if (mag_lo_ok) begin
                        len_d = sat_add(len_q, 9'd1);
                    end else if (OFF_C == 8'd1) begin
                        state_d = S_HOLD;
                        vld_d   = 1'b1;
                        act_d   = 1'b0;
                        plen_d  = len_q;
                        len_d   = '0;
                        hold_d  = '0;
                    end else begin
                        state_d = S_TAIL;
                        tail_d  = 8'd1;
                    end
                end
                S_TAIL: begin
                    // A pulse that recovers keeps its dip samples in the length.
                    if (mag_lo_ok) begin
                        state_d = S_ACTIVE;
                        len_d   = sat_add(len_q, {1'b0, tail_q} + 9'd1);
                        tail_d  = '0;
                    end else if (tail_q + 8'd1 == OFF_C) begin
                        state_d = S_HOLD;
                        vld_d   = 1'b1;
                        act_d   = 1'b0;
                        plen_d  = len_q;
                        len_d   = '0;
                        tail_d  = '0;
                        hold_d  = '0;
                    end else begin
                        tail_d = tail_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (hold_q + 16'd1 == HOLD_C) begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            run_q   <= '0;
            tail_q  <= '0;
            hold_q  <= '0;
            len_q   <= '0;
            srt_q   <= 1'b0;
            act_q   <= 1'b0;
            vld_q   <= 1'b0;
            plen_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            tail_q  <= tail_d;
            hold_q  <= hold_d;
            len_q   <= len_d;
            srt_q   <= srt_d;
            act_q   <= act_d;
            vld_q   <= vld_d;
            plen_q  <= plen_d;
        end
    end

    assign MAG_DOE  = mag_doe_q;
    assign MAG_DAT  = mag_q;
    assign PULSSRT  = srt_q;
    assign PULS_ACT = act_q;
    assign LEN_VLD  = vld_q;
    assign PULS_LEN = plen_q;

endmodule

// File: tb/tb_pulse_start_det.sv
// Scoreboard bench for pulse_start_det: a sample-level reference model predicts
// magnitudes, pulse starts and pulse lengths; a negedge monitor checks the DUT.
module tb_pulse_start_det;

    localparam int HI   = 2000;
    localparam int LO   = 1000;
    localparam int ON   = 8;
    localparam int OFF  = 32;
    localparam int HOLD = 1024;

    logic               CLK = 1'b0;
    logic               RST_N = 1'b1;
    logic               DDC_DEN = 1'b0;
    logic signed [15:0] DDC_DATI = '0;
    logic signed [15:0] DDC_DATQ = '0;
    logic               MAG_DOE;
    logic        [16:0] MAG_DAT;
    logic               PULSSRT;
    logic               PULS_ACT;
    logic               LEN_VLD;
    logic        [15:0] PULS_LEN;

    pulse_start_det dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .DDC_DEN  (DDC_DEN),
        .DDC_DATI (DDC_DATI),
        .DDC_DATQ (DDC_DATQ),
        .MAG_DOE  (MAG_DOE),
        .MAG_DAT  (MAG_DAT),
        .PULSSRT  (PULSSRT),
        .PULS_ACT (PULS_ACT),
        .LEN_VLD  (LEN_VLD),
        .PULS_LEN (PULS_LEN)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int mag_q[$];
    int iss_q[$];
    int start_q[$];
    int end_len_q[$];
    int end_idx_q[$];

    int samp_idx  = 0;
    int mags_seen = 0;
    int last_len  = 0;
    bit mon_en    = 1'b0;
    logic prev_act = 1'b0;

    int m_run = 0, m_len = 0, m_below = 0, m_hold = 0;
    bit m_in = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Pulse rules applied per sample magnitude, in sample-count terms.
    task automatic model_step(input int m);
        if (m_hold > 0) begin
            m_hold--;
        end else if (!m_in) begin
            m_run = (m >= HI) ? m_run + 1 : 0;
            if (m_run == ON) begin
                m_in    = 1'b1;
                m_len   = ON;
                m_below = 0;
                m_run   = 0;
                start_q.push_back(samp_idx);
            end
        end else if (m >= LO) begin
            m_len   = m_len + m_below + 1;
            if (m_len > 65535) m_len = 65535;
            m_below = 0;
        end else begin
            m_below++;
            if (m_below == OFF) begin
                end_len_q.push_back(m_len);
                end_idx_q.push_back(samp_idx);
                m_in    = 1'b0;
                m_below = 0;
                m_hold  = HOLD;
            end
        end
        samp_idx++;
    endtask

    task automatic send(input int i, input int q);
        @(posedge CLK);
        #1;
        DDC_DEN  = 1'b1;
        DDC_DATI = 16'(i);
        DDC_DATQ = 16'(q);
        mag_q.push_back(iabs(i) + iabs(q));
        iss_q.push_back(cyc);
        model_step(iabs(i) + iabs(q));
    endtask

    task automatic send_mag(input int m, input int n);
        for (int k = 0; k < n; k++) send(m - m / 2, -(m / 2));
    endtask

    task automatic gap(input int n);
        @(posedge CLK);
        #1;
        DDC_DEN = 1'b0;
        repeat (n - 1) @(posedge CLK);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        DDC_DEN = 1'b0;
        RST_N   = 1'b0;
        #1;
        check("rst_mag_doe", MAG_DOE, 0);
        check("rst_mag_dat", MAG_DAT, 0);
        check("rst_pulssrt", PULSSRT, 0);
        check("rst_puls_act", PULS_ACT, 0);
        check("rst_len_vld", LEN_VLD, 0);
        check("rst_puls_len", PULS_LEN, 0);
        mag_q.delete();
        iss_q.delete();
        start_q.delete();
        end_len_q.delete();
        end_idx_q.delete();
        samp_idx  = 0;
        mags_seen = 0;
        last_len  = 0;
        prev_act  = 1'b0;
        m_run = 0; m_len = 0; m_below = 0; m_hold = 0; m_in = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: strobes first (they refer to earlier MAG_DOE cycles), then magnitude.
    always @(negedge CLK) begin
        if (RST_N && mon_en) begin
            if (PULSSRT) begin
                if (start_q.size() == 0) check("pulssrt_expected", 0, 1);
                else check("pulssrt_sample_idx", mags_seen - 1, start_q.pop_front());
                check("puls_act_at_start", PULS_ACT, 1);
                check("puls_len_held", PULS_LEN, last_len);
            end
            if (LEN_VLD) begin
                if (end_len_q.size() == 0) check("len_vld_expected", 0, 1);
                else begin
                    last_len = end_len_q.pop_front();
                    check("len_vld_sample_idx", mags_seen - 1, end_idx_q.pop_front());
                    check("puls_len", PULS_LEN, last_len);
                end
                check("puls_act_at_end", PULS_ACT, 0);
            end
            if (PULS_ACT !== prev_act) check("act_edge_with_strobe", PULSSRT | LEN_VLD, 1);
            prev_act = PULS_ACT;
            if (MAG_DOE) begin
                if (mag_q.size() == 0) check("mag_doe_expected", 0, 1);
                else begin
                    check("mag_dat", MAG_DAT, mag_q.pop_front());
                    check("mag_latency", cyc - iss_q.pop_front(), 2);
                end
                mags_seen++;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lvl, len, m, im, sgn_i, sgn_q, r;
        #2;
        do_reset();

        // Basic pulse: MAG 2100 x8, then zeros until end, then the hold-off window.
        for (int k = 0; k < 8; k++) send(1500, -600);
        send_mag(0, 40);
        send_mag(300, HOLD);

        // Seven strong samples only: no pulse.
        send_mag(2100, 7);
        send_mag(0, 5);

        // Pulse with a recoverable dip: length 35.
        send_mag(2100, 20);
        send_mag(500, 10);
        send_mag(1200, 5);
        send_mag(0, 32);
        // Strong input inside hold-off is ignored, just after it starts a pulse.
        send_mag(5000, HOLD);
        send_mag(5000, 8);
        send_mag(0, 32);
        send_mag(0, HOLD);

        // Full-scale magnitude and length saturation.
        send(-32768, -32768);
        send_mag(3000, 69999);
        send_mag(0, 32);
        send_mag(0, HOLD);
        gap(4);

        // Reset during the 15th active sample, then a fresh run.
        send_mag(2100, ON + 15);
        do_reset();
        send_mag(2100, 8);
        send_mag(0, 40);
        send_mag(0, HOLD);

        // Randomized bursts around the thresholds, with occasional idle gaps.
        for (int b = 0; b < 160; b++) begin
            lvl = $urandom_range(0, 7);
            len = (lvl < 4) ? $urandom_range(1, 14) : $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                case (lvl)
                    0: m = HI;
                    1: m = HI - 1;
                    2: m = LO;
                    3: m = LO - 1;
                    4: m = $urandom_range(HI, 20000);
                    5: m = $urandom_range(LO, HI - 1);
                    default: m = $urandom_range(0, LO - 1);
                endcase
                im    = $urandom_range(0, m);
                sgn_i = $urandom_range(0, 1);
                sgn_q = $urandom_range(0, 1);
                send(sgn_i ? -im : im, sgn_q ? -(m - im) : (m - im));
                r = $urandom_range(0, 9);
                if (r == 0) gap($urandom_range(1, 3));
            end
        end
        gap(10);

        check("mag_q_drained", mag_q.size(), 0);
        check("start_q_drained", start_q.size(), 0);
        check("end_q_drained", end_len_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
